// File: rtl/line_clear_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// line_clear_pkg : board geometry, FSM states and score table for line_clear
// Rev 1.0
// ---------------------------------------------------------------------------
package line_clear_pkg;

  localparam int BOARD_W    = 10;
  localparam int BOARD_H    = 20;
  localparam int CELL_W     = 3;
  localparam int ROW_W      = BOARD_W * CELL_W;
  localparam int BOARD_BITS = BOARD_H * ROW_W;
  localparam int IDX_W      = $clog2(BOARD_H + 1);
  localparam int CNT_W      = 3;
  localparam int SCORE_W    = 16;

  localparam logic [SCORE_W-1:0] SCORE_1 = 16'd40;
  localparam logic [SCORE_W-1:0] SCORE_2 = 16'd100;
  localparam logic [SCORE_W-1:0] SCORE_3 = 16'd300;
  localparam logic [SCORE_W-1:0] SCORE_4 = 16'd1200;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_FILL = 2'd2,
    ST_DONE = 2'd3
  } lc_state_t;

  function automatic logic [SCORE_W-1:0] score_for(input logic [CNT_W-1:0] k);
    case (k)
      3'd0:    score_for = '0;
      3'd1:    score_for = SCORE_1;
      3'd2:    score_for = SCORE_2;
      3'd3:    score_for = SCORE_3;
      default: score_for = SCORE_4;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/line_clear_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// line_clear_if : request/result bundle between the game FSM and line_clear
// Rev 1.0  (score_total present only with LINE_CLEAR_SCORE_EN)
// ---------------------------------------------------------------------------
interface line_clear_if;
  import line_clear_pkg::*;

  logic                  start;
  logic [BOARD_BITS-1:0] board_in;
  logic                  busy;
  logic                  done;
  logic [BOARD_BITS-1:0] board_out;
  logic [CNT_W-1:0]      lines_cleared;
`ifdef LINE_CLEAR_SCORE_EN
  logic [SCORE_W-1:0]    score_total;

  modport master (output start, board_in,
                  input  busy, done, board_out, lines_cleared, score_total);
  modport slave  (input  start, board_in,
                  output busy, done, board_out, lines_cleared, score_total);
`else
  modport master (output start, board_in,
                  input  busy, done, board_out, lines_cleared);
  modport slave  (input  start, board_in,
                  output busy, done, board_out, lines_cleared);
`endif

endinterface
`default_nettype wire

// File: rtl/line_clear_row_full.sv
`default_nettype none
// ---------------------------------------------------------------------------
// line_clear_row_full : flags a row whose every cell is non-empty
// Rev 1.0
// ---------------------------------------------------------------------------
module line_clear_row_full
  import line_clear_pkg::*;
(
  input  logic [ROW_W-1:0] row,
  output logic             full
);

  logic [BOARD_W-1:0] occupied;

  for (genvar i = 0; i < BOARD_W; i++) begin : g_cell
    assign occupied[i] = |row[i*CELL_W +: CELL_W];
  end

  assign full = &occupied;

endmodule
`default_nettype wire

// File: rtl/line_clear.sv
`default_nettype none
// ---------------------------------------------------------------------------
// line_clear : removes full rows from the placed-brick board, compacting down
// Rev 1.0  (optional scoring via LINE_CLEAR_SCORE_EN)
// ---------------------------------------------------------------------------
module line_clear
  import line_clear_pkg::*;
(
  input  logic         main_clk,
  input  logic         rst_1plus,
  line_clear_if.slave  bus
);

  localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'(BOARD_H - 1);

  lc_state_t             state, state_nx;
  logic [IDX_W-1:0]      src, dst;
  logic [CNT_W-1:0]      cnt, cnt_nx;
  logic [CNT_W-1:0]      lines_q;
  logic [BOARD_BITS-1:0] work;
  logic [ROW_W-1:0]      src_row;
  logic                  src_full;

  assign src_row = work[int'(src)*ROW_W +: ROW_W];

  line_clear_row_full u_row_full (
    .row  (src_row),
    .full (src_full)
  );

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      ST_IDLE: if (bus.start) state_nx = ST_SCAN;
      ST_SCAN: begin
        if (src_full && cnt != '1) cnt_nx = cnt + 1'b1;
        if (src == LAST_ROW) state_nx = (cnt_nx != '0) ? ST_FILL : ST_DONE;
      end
      ST_FILL: if (dst == LAST_ROW) state_nx = ST_DONE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // work doubles as board_out; safe in place because dst never passes src
  always_ff @(posedge main_clk or posedge rst_1plus) begin
    if (rst_1plus) begin
      state   <= ST_IDLE;
      src     <= '0;
      dst     <= '0;
      cnt     <= '0;
      lines_q <= '0;
      work    <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            work <= bus.board_in;
            src  <= '0;
            dst  <= '0;
            cnt  <= '0;
          end
        end
        ST_SCAN: begin
          if (!src_full) begin
            work[int'(dst)*ROW_W +: ROW_W] <= src_row;
            dst <= dst + 1'b1;
          end
          if (src != LAST_ROW) src <= src + 1'b1;
        end
        ST_FILL: begin
          work[int'(dst)*ROW_W +: ROW_W] <= '0;
          dst <= dst + 1'b1;
        end
        default: ;
      endcase
      // latch the count as DONE is entered so it is valid alongside done
      if (state != ST_DONE && state_nx == ST_DONE) lines_q <= cnt_nx;
    end
  end

`ifdef LINE_CLEAR_SCORE_EN
  logic [SCORE_W-1:0] score_q;
  logic [SCORE_W:0]   score_sum;

  assign score_sum = {1'b0, score_q} + {1'b0, score_for(cnt)};

  always_ff @(posedge main_clk or posedge rst_1plus) begin
    if (rst_1plus) begin
      score_q <= '0;
    end else if (state == ST_DONE) begin
      score_q <= score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
    end
  end

  assign bus.score_total = score_q;
`endif

  assign bus.busy          = (state != ST_IDLE);
  assign bus.done          = (state == ST_DONE);
  assign bus.board_out     = work;
  assign bus.lines_cleared = lines_q;

endmodule
`default_nettype wire

// File: tb/tb_line_clear.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_line_clear : directed and randomized checks of line_clear against a row-filter model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_line_clear;
  import line_clear_pkg::*;

  typedef logic [BOARD_BITS-1:0] board_t;

  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  int   exp_score = 0;

  line_clear_if bus ();

  line_clear dut (
    .main_clk  (clk),
    .rst_1plus (rst),
    .bus       (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic board_t put(input board_t b, input int x, input int y, input int v);
    b[(y*BOARD_W + x)*CELL_W +: CELL_W] = CELL_W'(v);
    return b;
  endfunction

  function automatic int get(input board_t b, input int x, input int y);
    return int'(b[(y*BOARD_W + x)*CELL_W +: CELL_W]);
  endfunction

  function automatic board_t fill_row(input board_t b, input int y, input int v);
    for (int x = 0; x < BOARD_W; x++) b = put(b, x, y, v);
    return b;
  endfunction

  // Reference: keep the non-full rows in bottom-up order, pad the top with empties
  function automatic void model(input board_t b, output board_t exp_b, output int k);
    logic [ROW_W-1:0] kept[$];
    k = 0;
    for (int y = 0; y < BOARD_H; y++) begin
      bit full = 1;
      for (int x = 0; x < BOARD_W; x++) if (get(b, x, y) == 0) full = 0;
      if (full) k++;
      else kept.push_back(b[y*ROW_W +: ROW_W]);
    end
    exp_b = '0;
    foreach (kept[i]) exp_b[i*ROW_W +: ROW_W] = kept[i];
  endfunction

  function automatic int points(input int k);
    if (k == 0) return 0;
    if (k == 1) return 40;
    if (k == 2) return 100;
    if (k == 3) return 300;
    return 1200;
  endfunction

  function automatic void add_score(input int k);
    exp_score = exp_score + points(k);
    if (exp_score > 65535) exp_score = 65535;
  endfunction

  // Issue one request; returns the cycle (1 = first after start sampled) in which done rose, 0 on timeout
  task automatic do_op(input board_t b, output int dcyc, output logic busy1);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.board_in = b;
    @(posedge clk);
    #1;
    bus.start    = 1'b0;
    bus.board_in = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
                    $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
                    $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    dcyc  = 0;
    busy1 = 1'b0;
    for (int c = 1; c <= 60 && dcyc == 0; c++) begin
      @(negedge clk);
      if (c == 1) busy1 = bus.busy;
      if (bus.done) dcyc = c;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0;
    bus.board_in = '0;
    repeat (3) @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.done); end
    checks++; if (bus.board_out !== '0) begin errors++; $display("FAIL reset_board: got %h want 0", bus.board_out); end
    checks++; if (bus.lines_cleared !== 3'd0) begin errors++; $display("FAIL reset_lines: got %0d want 0", bus.lines_cleared); end
`ifdef LINE_CLEAR_SCORE_EN
    checks++; if (bus.score_total !== 16'd0) begin errors++; $display("FAIL reset_score: got %0d want 0", bus.score_total); end
`endif
    rst = 1'b0;
    exp_score = 0;
  endtask

  task automatic test_empty();
    int dcyc; logic busy1;
    do_op('0, dcyc, busy1);
    checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL empty_busy_next: got %b want 1", busy1); end
    checks++; if (dcyc != 21) begin errors++; $display("FAIL empty_latency: got %0d want 21", dcyc); end
    checks++; if (bus.lines_cleared !== 3'd0) begin errors++; $display("FAIL empty_lines: got %0d want 0", bus.lines_cleared); end
    checks++; if (bus.board_out !== '0) begin errors++; $display("FAIL empty_board: got %h want 0", bus.board_out); end
    add_score(0);
    @(negedge clk);
    checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL empty_after_done: got done=%b busy=%b want 0/0", bus.done, bus.busy); end
  endtask

  task automatic test_single();
    board_t b = '0; board_t eb; int k, dcyc; logic busy1;
    b = fill_row(b, 0, 1);
    b = put(b, 3, 1, 5);
    model(b, eb, k);
    do_op(b, dcyc, busy1);
    checks++; if (dcyc != 22) begin errors++; $display("FAIL single_latency: got %0d want 22", dcyc); end
    checks++; if (bus.lines_cleared !== 3'd1) begin errors++; $display("FAIL single_lines: got %0d want 1", bus.lines_cleared); end
    checks++; if (get(bus.board_out, 3, 0) != 5) begin errors++; $display("FAIL single_cell30: got %0d want 5", get(bus.board_out, 3, 0)); end
    checks++; if (bus.board_out !== eb) begin errors++; $display("FAIL single_board: got %h want %h", bus.board_out, eb); end
    add_score(k);
  endtask

  task automatic test_tetris();
    board_t b = '0; board_t eb; int k, dcyc; logic busy1;
    for (int y = 0; y < 4; y++) b = fill_row(b, y, y + 1);
    b = put(b, 0, 4, 2);
    model(b, eb, k);
    do_op(b, dcyc, busy1);
    checks++; if (dcyc != 25) begin errors++; $display("FAIL tetris_latency: got %0d want 25", dcyc); end
    checks++; if (bus.lines_cleared !== 3'd4) begin errors++; $display("FAIL tetris_lines: got %0d want 4", bus.lines_cleared); end
    checks++; if (bus.board_out !== eb || get(bus.board_out, 0, 0) != 2) begin
      errors++; $display("FAIL tetris_board: got %h want %h", bus.board_out, eb); end
    add_score(k);
    @(negedge clk);
`ifdef LINE_CLEAR_SCORE_EN
    checks++; if (bus.score_total !== 16'(exp_score)) begin
      errors++; $display("FAIL tetris_score: got %0d want %0d", bus.score_total, exp_score); end
`endif
  endtask

  task automatic test_split();
    board_t b = '0; board_t eb; int k, dcyc; logic busy1;
    b = fill_row(b, 0, 7);
    b = fill_row(b, 2, 6);
    b = put(b, 1, 1, 3);
    b = put(b, 2, 3, 4);
    model(b, eb, k);
    do_op(b, dcyc, busy1);
    checks++; if (dcyc != 23) begin errors++; $display("FAIL split_latency: got %0d want 23", dcyc); end
    checks++; if (bus.lines_cleared !== 3'd2) begin errors++; $display("FAIL split_lines: got %0d want 2", bus.lines_cleared); end
    checks++; if (get(bus.board_out, 1, 0) != 3 || get(bus.board_out, 2, 1) != 4 || bus.board_out !== eb) begin
      errors++; $display("FAIL split_board: got %h want %h", bus.board_out, eb); end
    add_score(k);
  endtask

  task automatic test_top_row();
    board_t b = '0; board_t eb; int k, dcyc; logic busy1;
    for (int y = 0; y < BOARD_H - 1; y++)
      for (int x = 1; x < BOARD_W; x++) b = put(b, x, y, $urandom_range(0, 7));
    b = fill_row(b, BOARD_H - 1, 2);
    model(b, eb, k);
    do_op(b, dcyc, busy1);
    checks++; if (dcyc != 22) begin errors++; $display("FAIL top_latency: got %0d want 22", dcyc); end
    checks++; if (bus.lines_cleared !== 3'd1) begin errors++; $display("FAIL top_lines: got %0d want 1", bus.lines_cleared); end
    checks++; if (bus.board_out[(BOARD_H-1)*ROW_W +: ROW_W] !== '0 ||
                  bus.board_out[(BOARD_H-1)*ROW_W-1:0] !== b[(BOARD_H-1)*ROW_W-1:0]) begin
      errors++; $display("FAIL top_board: got %h want %h", bus.board_out, eb); end
    add_score(k);
  endtask

  task automatic test_random();
    for (int it = 0; it < 10; it++) begin
      board_t b = '0; board_t eb; int k, dcyc, want_lines; logic busy1;
      for (int y = 0; y < BOARD_H; y++) begin
        bit full = (it == 9) ? (y < 9) : ($urandom_range(0, 2) == 0);
        for (int x = 0; x < BOARD_W; x++) b = put(b, x, y, $urandom_range(1, 7));
        if (!full) b = put(b, $urandom_range(0, BOARD_W - 1), y, 0);
      end
      model(b, eb, k);
      want_lines = (k > 7) ? 7 : k;
      do_op(b, dcyc, busy1);
      checks++; if (dcyc != 21 + k) begin errors++; $display("FAIL rand%0d_latency: got %0d want %0d", it, dcyc, 21 + k); end
      checks++; if (bus.lines_cleared !== 3'(want_lines)) begin
        errors++; $display("FAIL rand%0d_lines: got %0d want %0d", it, bus.lines_cleared, want_lines); end
      checks++; if (bus.board_out !== eb) begin errors++; $display("FAIL rand%0d_board: got %h want %h", it, bus.board_out, eb); end
      add_score(k);
    end
    @(negedge clk);
`ifdef LINE_CLEAR_SCORE_EN
    checks++; if (bus.score_total !== 16'(exp_score)) begin
      errors++; $display("FAIL rand_score: got %0d want %0d", bus.score_total, exp_score); end
`endif
  endtask

  task automatic test_start_ignored();
    board_t a = '0; board_t bb = '0; board_t eb; int k, dcyc = 0, ndone = 0;
    a = fill_row(a, 1, 3);
    a = put(a, 5, 0, 6);
    a = put(a, 4, 2, 1);
    bb = fill_row(bb, 0, 4);
    bb = fill_row(bb, 5, 4);
    model(a, eb, k);
    @(negedge clk);
    bus.start = 1'b1; bus.board_in = a;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int c = 1; c <= 45; c++) begin
      @(negedge clk);
      if (c == 4 || c == 21) begin bus.start = 1'b1; bus.board_in = bb; end
      else bus.start = 1'b0;
      if (bus.done) begin
        ndone++;
        if (dcyc == 0) begin
          dcyc = c;
          checks++; if (bus.board_out !== eb) begin
            errors++; $display("FAIL ignore_board: got %h want %h", bus.board_out, eb); end
        end
      end
    end
    bus.start = 1'b0;
    checks++; if (dcyc != 21 + k) begin errors++; $display("FAIL ignore_latency: got %0d want %0d", dcyc, 21 + k); end
    checks++; if (ndone != 1) begin errors++; $display("FAIL ignore_done_count: got %0d want 1", ndone); end
    add_score(k);
  endtask

  task automatic test_reset_mid();
    board_t b = '0; board_t eb; int k, dcyc; logic busy1;
    b = fill_row(b, 0, 5);
    b = put(b, 7, 1, 2);
    @(negedge clk);
    bus.start = 1'b1; bus.board_in = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", bus.busy); end
    checks++; if (bus.board_out !== '0) begin errors++; $display("FAIL midrst_board: got %h want 0", bus.board_out); end
    checks++; if (bus.lines_cleared !== 3'd0) begin errors++; $display("FAIL midrst_lines: got %0d want 0", bus.lines_cleared); end
`ifdef LINE_CLEAR_SCORE_EN
    checks++; if (bus.score_total !== 16'd0) begin errors++; $display("FAIL midrst_score: got %0d want 0", bus.score_total); end
`endif
    exp_score = 0;
    @(negedge clk);
    rst = 1'b0;
    model(b, eb, k);
    do_op(b, dcyc, busy1);
    checks++; if (dcyc != 22 || bus.board_out !== eb) begin
      errors++; $display("FAIL midrst_recover: got cycle %0d board %h want cycle 22 board %h", dcyc, bus.board_out, eb); end
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.board_in = '0;
    test_reset();
    test_empty();
    test_single();
    test_tetris();
    test_split();
    test_top_row();
    test_random();
    test_start_ignored();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
